// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: host/decoder controls into the sequencer, PC and status back out.
interface inst_fetch_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Halt;
  logic             Jump;
  logic             BranchEn;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             Fault;
  logic [CNT_W-1:0] InstCount;

  modport master (
    output Start, Halt, Jump, BranchEn, Target,
    input  ProgCtr, Running, Done, Fault, InstCount
  );

  modport slave (
    input  Start, Halt, Jump, BranchEn, Target,
    output ProgCtr, Running, Done, Fault, InstCount
  );
endinterface

// File: rtl/inst_fetch.sv
// Program-counter / fetch sequencer: load, run, done, with retired-instruction count and overflow fault.
//   state  | meaning
//   S_IDLE | out of reset, PC parked at START_ADDR
//   S_LOAD | Start held: PC, count and fault cleared
//   S_RUN  | one instruction retires per cycle
//   S_DONE | halted or faulted; PC, count, fault frozen
module inst_fetch #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int          CNT_W      = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  inst_fetch_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  PC_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             running_q;
  logic             done_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (bus.Start) begin
      state_d = S_LOAD;
      pc_d    = START_PC;
      cnt_d   = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          // Halt outranks a taken jump; a taken jump from PC_MAX is legal.
          if (bus.Halt) begin
            state_d = S_DONE;
          end else if (bus.Jump && bus.BranchEn) begin
            pc_d = bus.Target;
          end else if (pc_q == PC_MAX) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        S_IDLE, S_DONE: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign bus.ProgCtr   = pc_q;
  assign bus.InstCount = cnt_q;
  assign bus.Fault     = fault_q;
  assign bus.Running   = running_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic against a cycle-level reference model.
module tb_inst_fetch;
  logic       clk;
  logic       rst;
  logic       start_r, halt_r, jump_r, ben_r;
  logic [9:0] target_r;
  int         errors = 0;
  int         checks = 0;

  inst_fetch_if #(.PC_W(10), .CNT_W(16)) bus ();
  inst_fetch_if #(.PC_W(10), .CNT_W(4))  bus4 ();

  assign bus.Start     = start_r;
  assign bus.Halt      = halt_r;
  assign bus.Jump      = jump_r;
  assign bus.BranchEn  = ben_r;
  assign bus.Target    = target_r;
  assign bus4.Start    = start_r;
  assign bus4.Halt     = halt_r;
  assign bus4.Jump     = jump_r;
  assign bus4.BranchEn = ben_r;
  assign bus4.Target   = target_r;

  inst_fetch #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (.CLK(clk), .Reset(rst), .bus(bus));
  inst_fetch #(.PC_W(10), .START_ADDR(0), .CNT_W(4))  dut4 (.CLK(clk), .Reset(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=load 2=run 3=done; count kept unbounded, clamped per width at compare.
  int m_mode, m_pc, m_cnt, m_prev;
  bit m_fault, m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_fault = 0; m_done = 0;
    end else begin
      m_prev = m_mode;
      if (start_r) begin
        m_mode = 1; m_pc = 0; m_cnt = 0; m_fault = 0;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_cnt = m_cnt + 1;
        if (halt_r) m_mode = 3;
        else if (jump_r && ben_r) m_pc = int'(target_r);
        else if (m_pc + 1 > 1023) begin m_fault = 1; m_mode = 3; end
        else m_pc = m_pc + 1;
      end
      m_done = (m_mode == 3) && (m_prev != 3);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("pc", int'(bus.ProgCtr), m_pc);
    chk("running", int'(bus.Running), int'(m_mode == 2));
    chk("done", int'(bus.Done), int'(m_done));
    chk("fault", int'(bus.Fault), int'(m_fault));
    chk("count16", int'(bus.InstCount), (m_cnt > 65535) ? 65535 : m_cnt);
    chk("pc_w4", int'(bus4.ProgCtr), m_pc);
    chk("count4", int'(bus4.InstCount), (m_cnt > 15) ? 15 : m_cnt);
  end

  task automatic cyc(input bit s, input bit h, input bit j, input bit b, input int t);
    @(negedge clk);
    start_r = s; halt_r = h; jump_r = j; ben_r = b; target_r = t[9:0];
    @(posedge clk);
    #2;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic launch();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    start_r = 0; halt_r = 0; jump_r = 0; ben_r = 0; target_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rst_pc", int'(bus.ProgCtr), 0);
    chk("rst_running", int'(bus.Running), 0);
    chk("rst_done", int'(bus.Done), 0);
    chk("rst_fault", int'(bus.Fault), 0);
    chk("rst_count", int'(bus.InstCount), 0);

    // fetch order after a 2-cycle Start pulse
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("fetch_seq", int'(bus.ProgCtr), i);
    end
    nop(34);
    chk("pc_37", int'(bus.ProgCtr), 37);
    #1 rst = 1'b0;
    #1;
    chk("midrun_rst_pc", int'(bus.ProgCtr), 0);
    chk("midrun_rst_running", int'(bus.Running), 0);
    chk("midrun_rst_count", int'(bus.InstCount), 0);
    @(negedge clk) rst = 1'b1;

    // halt at 5
    launch();
    nop(5);
    chk("pre_halt_pc", int'(bus.ProgCtr), 5);
    cyc(0, 1, 0, 0, 0);
    chk("halt_pc", int'(bus.ProgCtr), 5);
    chk("halt_count", int'(bus.InstCount), 6);
    chk("halt_done", int'(bus.Done), 1);
    chk("halt_running", int'(bus.Running), 0);
    cyc(0, 0, 0, 0, 0);
    chk("done_pulse_end", int'(bus.Done), 0);

    // taken and not-taken jumps
    launch();
    nop(4);
    cyc(0, 0, 1, 1, 200);
    chk("jump_taken", int'(bus.ProgCtr), 200);
    cyc(0, 0, 1, 0, 77);
    chk("jump_not_taken", int'(bus.ProgCtr), 201);

    // halt beats a taken jump
    launch();
    nop(12);
    cyc(0, 1, 1, 1, 9);
    chk("halt_prio_pc", int'(bus.ProgCtr), 12);
    chk("halt_prio_done", int'(bus.Done), 1);

    // overflow fault, then restart from DONE
    launch();
    cyc(0, 0, 1, 1, 1023);
    chk("jump_1023", int'(bus.ProgCtr), 1023);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_fault", int'(bus.Fault), 1);
    chk("ovf_pc", int'(bus.ProgCtr), 1023);
    chk("ovf_running", int'(bus.Running), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("load_pc", int'(bus.ProgCtr), 0);
      chk("load_count", int'(bus.InstCount), 0);
      chk("load_fault", int'(bus.Fault), 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("resume_pc", int'(bus.ProgCtr), 0);
    chk("resume_running", int'(bus.Running), 1);
    cyc(0, 0, 1, 1, 1023);
    cyc(0, 0, 1, 1, 3);
    chk("jump_from_max", int'(bus.ProgCtr), 3);
    chk("jump_from_max_fault", int'(bus.Fault), 0);

    // count saturation on the 4-bit instance
    launch();
    nop(20);
    chk("count16_20", int'(bus.InstCount), 20);
    chk("count4_sat", int'(bus4.InstCount), 15);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int t;
      t = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Program-counter / fetch sequencer that sits directly upstream of the control decoder. It drives the instruction ROM address each cycle and consumes the decoder's Jump/BranchEn outputs to choose between sequential advance and a taken branch. It also owns run/halt sequencing: load, run, done. It keeps a retired-instruction count and reports an address-overflow fault.

Parameters:
PC_W, 10, program-counter / instruction-ROM address width
START_ADDR, 0, address loaded into ProgCtr while Start is asserted
CNT_W, 16, width of the retired-instruction counter (saturating)

Ports:
CLK  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Start  in  1  level request from testbench/host: hold PC at START_ADDR; run begins on the cycle after Start falls
Halt  in  1  decoded halt instruction at current ProgCtr (valid in RUN only)
Jump  in  1  decoder: current instruction is a jump
BranchEn  in  1  decoder: jump condition true (meaningful only with Jump=1)
Target  in  PC_W  absolute branch target for the current instruction (from the branch-target LUT)
ProgCtr  out  PC_W  instruction ROM address
Running  out  1  1 while in RUN
Done  out  1  single-cycle pulse on entry to DONE
Fault  out  1  sticky: sequential increment attempted from PC = 2^PC_W-1
InstCount  out  CNT_W  instructions retired since last LOAD, saturating

Behaviour:
- Reset=0, asynchronous:
  - state=IDLE
  - ProgCtr=START_ADDR
  - Running=0, Done=0, Fault=0, InstCount=0
  - Reset takes effect immediately, even mid-run; no partial update survives.
- States: IDLE, LOAD, RUN, DONE. All registers update on rising CLK only.
- IDLE:
  - Start=1 -> LOAD.
  - Otherwise hold; ProgCtr holds.
- LOAD, entered from any state whenever Start=1 (Start has priority over everything except reset):
  - ProgCtr<=START_ADDR, InstCount<=0, Fault<=0.
  - Stay while Start=1; Start=0 -> RUN.
  - The first instruction fetched in RUN is at START_ADDR.
- RUN, each cycle with Start=0; one instruction retires per cycle, zero-latency next-PC (combinational select, registered PC):
  - Halt=1 -> state DONE, ProgCtr holds, InstCount+1. Halt beats Jump/BranchEn in the same cycle.
  - Jump=1 & BranchEn=1 -> ProgCtr<=Target, InstCount+1.
  - Jump=1 & BranchEn=0 (not taken) -> ProgCtr<=ProgCtr+1, InstCount+1.
  - Jump=0 -> ProgCtr<=ProgCtr+1, InstCount+1.
  - Sequential increment with ProgCtr=2^PC_W-1 -> no wrap:
    - Fault<=1, state DONE, ProgCtr holds, InstCount+1.
    - A taken jump from that address is legal and does not fault.
  - Target is used verbatim; no range check (every PC_W value is a legal address).
- DONE:
  - ProgCtr, InstCount and Fault hold; Running=0.
  - Done=1 for exactly the first cycle after entry, then 0.
  - Start=1 -> LOAD. Halt, Jump and BranchEn are ignored.
- Running is a registered output, equal to (state==RUN).
- InstCount saturates at 2^CNT_W-1; it never wraps.
- Halt, Jump and BranchEn are ignored in IDLE, LOAD and DONE.

Test Plan:
- Reset=0 mid-RUN at ProgCtr=37 -> same instant: ProgCtr=0, Running=0, InstCount=0. Reset=1, Start pulse 2 cycles -> RUN fetches addr 0,1,2,3 on successive cycles.
- RUN from 0 with no jumps for 5 cycles, then Halt=1 at ProgCtr=5 -> next edge state DONE, ProgCtr=5, InstCount=6, Done high exactly 1 cycle.
- At ProgCtr=4: Jump=1, BranchEn=1, Target=200 -> ProgCtr=200. At ProgCtr=200: Jump=1, BranchEn=0 -> ProgCtr=201.
- Halt=1 with Jump=1, BranchEn=1, Target=9 in the same cycle at ProgCtr=12 -> DONE, ProgCtr stays 12.
- Jump to Target=1023 (PC_W=10), then no jump -> Fault=1, DONE, ProgCtr=1023. Repeat with Jump=1, BranchEn=1, Target=3 at 1023 -> ProgCtr=3, Fault=0.
- From DONE, assert Start for 3 cycles -> ProgCtr=0, InstCount=0, Fault=0 during LOAD; RUN resumes at 0. CNT_W=4 run of 20 instructions -> InstCount=15.
